// File: rtl/tlp_arb_pkg.sv
// tlp_arb_pkg: shared state enum and field widths for the TLP transmit arbiter.
package tlp_arb_pkg;
   typedef enum logic {IDLE, LOCKED} state_e;
   localparam int TLP_EMPTY_W   = 3;
   localparam int TLP_CHANNEL_W = 8;
   localparam int MAX_SOURCES   = 8;
endpackage

// File: rtl/tlp_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, search starts just after last_i.
// With TLP_TX_ARB_STRICT_PRIO_EN defined, req_i[0] always wins.
module rr_pick #(
   parameter  int N  = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [IW-1:0] win_o,
   output logic          any_o
);
   assign any_o = |req_i;
   // Descending scan so the nearest requester after last_i is written last.
   always_comb begin
      win_o = '0;
      for (int k = N; k >= 1; k--)
         if (req_i[(int'(last_i) + k) % N]) win_o = IW'((int'(last_i) + k) % N);
`ifdef TLP_TX_ARB_STRICT_PRIO_EN
      if (req_i[0]) win_o = '0;
`endif
   end
endmodule

// File: rtl/tlp_tx_arbiter.sv
// tlp_tx_arbiter: packet-granular arbiter of NUM_SOURCES Avalon-ST TLP sources onto one stream.
// Define TLP_TX_ARB_STRICT_PRIO_EN to give source 0 strict priority at every pick point.
module tlp_tx_arbiter
   import tlp_arb_pkg::*;
#(
   parameter int NUM_SOURCES = 2,
   parameter int DATA_W      = 256
) (
   input  logic                                      clk,
   input  logic                                      reset_n,
   input  logic [NUM_SOURCES-1:0][DATA_W-1:0]        src_data,
   input  logic [NUM_SOURCES-1:0][TLP_EMPTY_W-1:0]   src_empty,
   input  logic [NUM_SOURCES-1:0]                    src_startofpacket,
   input  logic [NUM_SOURCES-1:0]                    src_endofpacket,
   input  logic [NUM_SOURCES-1:0]                    src_valid,
   output logic [NUM_SOURCES-1:0]                    src_ready,
   output logic [DATA_W-1:0]                         tlp_tx_st_data,
   output logic [TLP_EMPTY_W-1:0]                    tlp_tx_st_empty,
   output logic                                      tlp_tx_st_startofpacket,
   output logic                                      tlp_tx_st_endofpacket,
   output logic                                      tlp_tx_st_valid,
   output logic [TLP_CHANNEL_W-1:0]                  tlp_tx_st_channel,
   input  logic                                      tlp_tx_st_ready,
   output logic                                      sop_err
);
   localparam int IW = $clog2(NUM_SOURCES);
   state_e        state_q, state_d;
   logic [IW-1:0] grant_q, grant_d, last_q, last_d, win;
   logic          first_q, first_d, sop_err_q, sop_err_d;
   logic          any, locked, g_valid, hs;
   assign locked  = state_q == LOCKED;
   assign g_valid = locked && src_valid[grant_q];
   assign hs      = g_valid && tlp_tx_st_ready;
   // While locked the only pick point is the eop handshake, where the search starts after grant.
   rr_pick #(.N(NUM_SOURCES)) u_pick (
      .req_i (src_valid),
      .last_i(locked ? grant_q : last_q),
      .win_o (win),
      .any_o (any)
   );
   assign tlp_tx_st_valid         = g_valid;
   assign tlp_tx_st_data          = locked ? src_data[grant_q] : '0;
   assign tlp_tx_st_empty         = locked ? src_empty[grant_q] : '0;
   assign tlp_tx_st_startofpacket = locked && src_startofpacket[grant_q];
   assign tlp_tx_st_endofpacket   = locked && src_endofpacket[grant_q];
   assign tlp_tx_st_channel       = locked ? TLP_CHANNEL_W'(grant_q) : '0;
   assign src_ready               = (locked && tlp_tx_st_ready) ? NUM_SOURCES'(1) << grant_q : '0;
   assign sop_err                 = sop_err_q;
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      first_d   = first_q;
      sop_err_d = sop_err_q | (g_valid & first_q & ~src_startofpacket[grant_q]);
      if (!locked) begin
         if (any) begin
            state_d = LOCKED;
            grant_d = win;
            first_d = 1'b1;
         end
      end else if (hs) begin
         first_d = 1'b0;
         if (src_endofpacket[grant_q]) begin
            last_d  = grant_q;
            first_d = any;
            grant_d = any ? win : grant_q;
            state_d = any ? LOCKED : IDLE;
         end
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         last_q    <= IW'(NUM_SOURCES - 1);
         first_q   <= 1'b0;
         sop_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         first_q   <= first_d;
         sop_err_q <= sop_err_d;
      end
   end
endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// tb_tlp_tx_arbiter: directed and randomized checks of tlp_tx_arbiter against a packet-level model.
module tb_tlp_tx_arbiter;
   localparam int N = 3;
   logic                   clk = 1'b0, reset_n = 1'b0;
   logic [N-1:0][255:0]    src_data = '0;
   logic [N-1:0][2:0]      src_empty = '0;
   logic [N-1:0]           src_sop = '0, src_eop = '0, src_valid = '0, src_ready;
   logic [255:0]           tlp_tx_st_data;
   logic [2:0]             tlp_tx_st_empty;
   logic                   tlp_tx_st_startofpacket, tlp_tx_st_endofpacket, tlp_tx_st_valid;
   logic [7:0]             tlp_tx_st_channel;
   logic                   rdy = 1'b0, sop_err;
   int tests = 0, fails = 0;
   // reference model: who holds the stream, who was last served, sticky error
   bit m_lk, m_first, m_err;
   int m_g, m_last;
   // source drivers
   int act[N], bt[N], ln[N];
   logic [N-1:0] en = '1;
   int sp = 100, vp = 100, rp = 100, fl = 0;
   int obs_ch[$];

   tlp_tx_arbiter #(.NUM_SOURCES(N), .DATA_W(256)) dut (
      .clk(clk), .reset_n(reset_n),
      .src_data(src_data), .src_empty(src_empty),
      .src_startofpacket(src_sop), .src_endofpacket(src_eop), .src_valid(src_valid),
      .src_ready(src_ready),
      .tlp_tx_st_data(tlp_tx_st_data), .tlp_tx_st_empty(tlp_tx_st_empty),
      .tlp_tx_st_startofpacket(tlp_tx_st_startofpacket), .tlp_tx_st_endofpacket(tlp_tx_st_endofpacket),
      .tlp_tx_st_valid(tlp_tx_st_valid), .tlp_tx_st_channel(tlp_tx_st_channel),
      .tlp_tx_st_ready(rdy), .sop_err(sop_err)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // next requester strictly after 'last', wrapping; source 0 first in strict builds
   function automatic int rr(logic [N-1:0] r, int last);
`ifdef TLP_TX_ARB_STRICT_PRIO_EN
      if (r[0]) return 0;
`endif
      for (int k = 1; k <= N; k++)
         if (r[(last + k) % N]) return (last + k) % N;
      return 0;
   endfunction

   task automatic drive_rand();
      for (int i = 0; i < N; i++) begin
         if (!act[i] && en[i] && $urandom_range(99) < sp) begin
            act[i] = 1; bt[i] = 0;
            ln[i] = fl != 0 ? fl : int'($urandom_range(1, 4));
         end
         src_valid[i] = act[i] != 0 && $urandom_range(99) < vp;
         src_sop[i]   = bt[i] == 0;
         src_eop[i]   = bt[i] == ln[i] - 1;
         src_data[i]  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         src_empty[i] = 3'($urandom_range(7));
      end
      rdy = $urandom_range(99) < rp;
   endtask

   task automatic step();
      logic [N-1:0] er;
      bit ev;
      int g;
      #1;
      g  = m_g;
      ev = m_lk && src_valid[g];
      er = m_lk ? (N'(rdy) << g) : '0;
      chk("valid", 256'(tlp_tx_st_valid), 256'(ev));
      chk("src_ready", 256'(src_ready), 256'(er));
      chk("sop_err", 256'(sop_err), 256'(m_err));
      if (ev) begin
         chk("data", tlp_tx_st_data, src_data[g]);
         chk("empty", 256'(tlp_tx_st_empty), 256'(src_empty[g]));
         chk("sop", 256'(tlp_tx_st_startofpacket), 256'(src_sop[g]));
         chk("eop", 256'(tlp_tx_st_endofpacket), 256'(src_eop[g]));
         chk("channel", 256'(tlp_tx_st_channel), 256'(g));
      end
      if (tlp_tx_st_valid && rdy) obs_ch.push_back(int'(tlp_tx_st_channel));
      if (m_lk && m_first && src_valid[g] && !src_sop[g]) m_err = 1;
      if (!m_lk) begin
         if (|src_valid) begin m_g = rr(src_valid, m_last); m_lk = 1; m_first = 1; end
      end else if (ev && rdy) begin
         m_first = 0;
         if (src_eop[g]) begin
            m_last = g;
            if (|src_valid) begin m_g = rr(src_valid, g); m_first = 1; end
            else m_lk = 0;
         end
      end
      for (int i = 0; i < N; i++)
         if (src_valid[i] && er[i]) begin
            bt[i]++;
            if (src_eop[i]) begin act[i] = 0; bt[i] = 0; end
         end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_valid", 256'(tlp_tx_st_valid), 256'(0));
      chk("rst_src_ready", 256'(src_ready), 256'(0));
      chk("rst_channel", 256'(tlp_tx_st_channel), 256'(0));
      chk("rst_sop_err", 256'(sop_err), 256'(0));
      for (int i = 0; i < N; i++) begin act[i] = 0; bt[i] = 0; end
      src_valid = '0;
      m_lk = 0; m_first = 0; m_err = 0; m_g = 0; m_last = N - 1;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      do_reset();
      // sources 0 and 1 stream 2-beat packets back to back
      en = 3'b011; sp = 100; vp = 100; rp = 100; fl = 2;
      obs_ch.delete();
      repeat (9) begin drive_rand(); step(); end
      chk("b2b_beats", 256'(obs_ch.size()), 256'(8));
      for (int k = 0; k < obs_ch.size() && k < 8; k++)
         chk($sformatf("b2b_ch%0d", k), 256'(obs_ch[k]), 256'((k / 2) % 2));
      // random traffic with stalls and valid gaps
      en = '1; sp = 40; vp = 75; rp = 70; fl = 0;
      repeat (3000) begin drive_rand(); step(); end
      // reset while source 0 presents beat 2 of 4
      do_reset();
      en = 3'b001; sp = 100; vp = 100; rp = 100; fl = 4;
      repeat (3) begin drive_rand(); step(); end
      drive_rand();
      chk("mid_pkt_valid_before", 256'(tlp_tx_st_valid), 256'(1));
      do_reset();
      en = '1;
      drive_rand(); step();
      drive_rand();
      #1;
      chk("post_rst_valid", 256'(tlp_tx_st_valid), 256'(1));
      chk("post_rst_channel", 256'(tlp_tx_st_channel), 256'(0));
      step();
      // first granted beat lacking startofpacket
      do_reset();
      src_valid = 3'b001; src_sop = '0; src_eop = 3'b001; rdy = 1'b1;
      src_data[0] = {8{32'hA5A5_0001}}; src_empty[0] = 3'h5;
      step();
      step();
      src_valid = '0;
      repeat (4) step();
      chk("sop_err_sticky", 256'(sop_err), 256'(1));
      do_reset();
      chk("sop_err_cleared", 256'(sop_err), 256'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
